priority_encoder_seq: RTL and testbench

Sequential encoder, the transmit-side counterpart of the team's combinational decoders. It accepts an N-bit request vector over a valid/ready handshake and latches it. It then emits the binary index of every set bit, one index per output handshake, lowest index first, with a last-beat marker. It sits between request-collecting logic and any consumer of binary indices, such as a decoder bank, arbiter grant path or interrupt dispatcher.

---
 rtl/priority_encoder_seq_if.sv | 28 ++
 rtl/priority_encoder_seq.sv | 98 +++++++++
 tb/tb_priority_encoder_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_encoder_seq_if.sv
// Handshake bundle for priority_encoder_seq: request-vector input channel,
// index output channel and the all-zero-vector pulse.
interface priority_encoder_seq_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_last;
    logic [W:0]   out_seq;
    logic         zero_pulse;

    // Upstream producer / downstream consumer side
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_seq, zero_pulse
    );

    // Encoder side
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_seq, zero_pulse
    );
endinterface

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: latches an N-bit request vector and emits the
// binary index of every set bit, lowest first, one index per output beat.
module priority_encoder_seq #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    priority_encoder_seq_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [N-1:0] VEC_ONE = N'(1);
    localparam logic [W:0]   SEQ_ONE = (W + 1)'(1);

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W:0]   seq_q, seq_d;
    logic         zero_q, zero_d;

    logic [W-1:0] low_idx;
    logic         one_left;

    // Lowest pending index and "single bit remaining" flag, from registered state only
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = W'(i);
            end
        end
        one_left = (pending_q != '0) && ((pending_q & (pending_q - VEC_ONE)) == '0);
    end

    // Next-state logic for the IDLE/SEND controller and its datapath
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        seq_d     = seq_q;
        zero_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_vec != '0) begin
                        pending_d = bus.in_vec;
                        seq_d     = '0;
                        state_d   = SEND;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (one_left) begin
                        pending_d = '0;
                        seq_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        // Clearing the lowest set bit retires exactly out_idx
                        pending_d = pending_q & (pending_q - VEC_ONE);
                        seq_d     = seq_q + SEQ_ONE;
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            seq_q     <= '0;
            zero_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            zero_q    <= zero_d;
        end
    end

    // Outputs decode registered state; index fields are forced to zero when idle
    assign bus.out_valid  = (state_q == SEND);
    assign bus.in_ready   = (state_q == IDLE) && rst_n;
    assign bus.out_idx    = bus.out_valid ? low_idx : '0;
    assign bus.out_last   = bus.out_valid && one_left;
    assign bus.out_seq    = bus.out_valid ? seq_q : '0;
    assign bus.zero_pulse = zero_q;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Self-checking bench for priority_encoder_seq: scenario tasks push expected
// beats into a scoreboard queue, a negedge monitor pops and compares them.
module tb_priority_encoder_seq;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct {
        logic [W-1:0] idx;
        logic [W:0]   seq;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_encoder_seq_if #(.N(N), .W(W)) bus ();
    priority_encoder_seq #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    errors = 0;
    int    checks = 0;
    int    ready_mode = 0;   // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: held low
    int    ready_phase = 0;
    beat_t sb[$];

    // out_ready driver, updated just after each rising edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (ready_phase % 3 == 0);
                    ready_phase++;
                end
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard compare on each beat, stall-hold and idle-zero checks
    initial begin
        beat_t e;
        logic         held_v;
        logic [W-1:0] h_idx;
        logic [W:0]   h_seq;
        logic         h_last;
        held_v = 1'b0;
        h_idx = '0;
        h_seq = '0;
        h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (held_v) begin
                    checks++;
                    if (bus.out_idx !== h_idx || bus.out_seq !== h_seq || bus.out_last !== h_last) begin
                        errors++;
                        $display("FAIL stall_hold: got idx=%0d seq=%0d last=%0b, want idx=%0d seq=%0d last=%0b",
                                 bus.out_idx, bus.out_seq, bus.out_last, h_idx, h_seq, h_last);
                    end
                end
                held_v = !bus.out_ready;
                h_idx = bus.out_idx;
                h_seq = bus.out_seq;
                h_last = bus.out_last;
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_in_send: got %b, want 0", bus.in_ready);
                end
                if (bus.out_ready && rst_n) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: got idx=%0d seq=%0d last=%0b, want no beat",
                                 bus.out_idx, bus.out_seq, bus.out_last);
                    end else begin
                        e = sb.pop_front();
                        if (bus.out_idx !== e.idx || bus.out_seq !== e.seq || bus.out_last !== e.last) begin
                            errors++;
                            $display("FAIL beat: got idx=%0d seq=%0d last=%0b, want idx=%0d seq=%0d last=%0b",
                                     bus.out_idx, bus.out_seq, bus.out_last, e.idx, e.seq, e.last);
                        end
                    end
                end
            end else begin
                held_v = 1'b0;
                checks++;
                if (bus.out_idx !== '0 || bus.out_last !== 1'b0 || bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: got valid=%b idx=%0d last=%b, want 0/0/0",
                             bus.out_valid, bus.out_idx, bus.out_last);
                end
            end
        end
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one beat per set bit, ascending, last on the final one
    task automatic push_expected(input logic [N-1:0] vec);
        int cnt;
        int s;
        beat_t b;
        cnt = $countones(vec);
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                b.idx = W'(i);
                b.seq = (W + 1)'(s);
                b.last = (s == cnt - 1);
                sb.push_back(b);
                s++;
            end
        end
    endtask

    // Offer a vector, wait for acceptance, then wait for all its beats to drain
    task automatic send_vec(input logic [N-1:0] vec, input bit noise);
        bit got;
        bit done;
        tick();
        push_expected(vec);
        bus.in_vec = vec;
        bus.in_valid = 1'b1;
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b, want 1 within 50 cycles", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        if (noise) begin
            bus.in_valid = 1'b1;
            bus.in_vec = 8'h0F;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== (vec != '0)) begin
            errors++;
            $display("FAIL latency: got out_valid=%b, want %b one cycle after accept", bus.out_valid, (vec != '0));
        end
        done = 0;
        for (int c = 0; c < 200; c++) begin
            if (sb.size() == 0) bus.in_valid = 1'b0;
            if (sb.size() == 0 && bus.out_valid === 1'b0) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding, want 0", sb.size());
            sb.delete();
        end else if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_vec: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_last !== 1'b0 ||
            bus.out_seq !== '0 || bus.zero_pulse !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b idx=%0d last=%b seq=%0d zp=%b rdy=%b, want all 0",
                     bus.out_valid, bus.out_idx, bus.out_last, bus.out_seq, bus.zero_pulse, bus.in_ready);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        ready_mode = 0;
        send_vec(8'b1010_0100, 0);
    endtask

    task automatic test_single_bits();
        ready_mode = 0;
        send_vec(8'h80, 0);
        send_vec(8'h01, 0);
    endtask

    task automatic test_stall();
        ready_phase = 0;
        ready_mode = 1;
        send_vec(8'hFF, 1);
        ready_mode = 0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignored_in_send: got out_valid=%b, want 0 (0F must not be accepted)", bus.out_valid);
            end
        end
    endtask

    task automatic test_zero();
        ready_mode = 0;
        tick();
        bus.in_vec = 8'h00;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.zero_pulse !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_pre: got zp=%b rdy=%b, want 0/1", bus.zero_pulse, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.zero_pulse !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse: got zp=%b valid=%b rdy=%b, want 1/0/1", bus.zero_pulse, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.zero_pulse !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse_width: got zp=%b valid=%b, want 0/0", bus.zero_pulse, bus.out_valid);
        end
        send_vec(8'h10, 0);
    endtask

    task automatic test_reset_mid();
        beat_t b;
        ready_mode = 0;
        tick();
        b.idx = 3'd4;
        b.seq = 4'd0;
        b.last = 1'b0;
        sb.push_back(b);
        bus.in_vec = 8'hF0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        tick();                     // accept edge
        bus.in_valid = 1'b0;
        @(negedge clk);             // idx 4 beat presented with out_ready=1
        ready_mode = 3;
        tick();                     // beat idx 4 taken
        rst_n = 1'b0;
        @(posedge clk);             // reset edge
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_seq !== '0 || bus.in_ready !== 1'b0 || bus.out_idx !== '0) begin
            errors++;
            $display("FAIL reset_mid_send: got valid=%b seq=%0d rdy=%b idx=%0d, want 0/0/0/0",
                     bus.out_valid, bus.out_seq, bus.in_ready, bus.out_idx);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_beat4: got %0d beats outstanding, want 0", sb.size());
            sb.delete();
        end
        tick();
        rst_n = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got rdy=%b valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
        send_vec(8'h02, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            v = N'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) v = '0;
            send_vec(v, 0);
        end
        ready_mode = 0;
    endtask

    task automatic test_back_to_back();
        ready_mode = 0;
        send_vec(8'h03, 0);
        send_vec(8'hC0, 0);
        send_vec(8'h81, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        test_reset();
        test_basic();
        test_single_bits();
        test_stall();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
